instr_fetcher: RTL and testbench

Fetch-stage front end sitting directly downstream of the branch predictor and upstream of the decoder. Holds the fetch PC, issues one instruction request at a time to the instruction cache, and presents the PC to the predictor. On each response it computes the next PC from the predictor's taken bit and the instruction's immediate. It buffers fetched instructions in a small FIFO for the decoder and redirects on a ROB flush.

---
 rtl/instr_fetcher.sv | 124 ++++++++++++
 tb/tb_instr_fetcher.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetcher.sv
// instr_fetcher: fetch PC and request FSM, next-PC prediction and a decode FIFO.
// Define IF_STATIC_JAL_EN to redirect JAL statically instead of waiting for a ROB flush.
module instr_fetcher #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        if_to_ic_valid,
    output logic [31:0] if_to_ic_PC,
    input  logic        ic_to_if_ready,
    input  logic [31:0] ic_to_if_inst,
    output logic [31:0] if_to_pr_PC,
    input  logic        pr_to_if_prediction,
    output logic        if_to_dec_valid,
    output logic [31:0] if_to_dec_inst,
    output logic [31:0] if_to_dec_PC,
    output logic        if_to_dec_pred,
    input  logic        dec_to_if_ready,
    input  logic        rob_to_if_flush,
    input  logic [31:0] rob_to_if_target
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t        r_state, w_next_state;
    logic [31:0]   r_pc, w_next_pc;
    logic          w_next_pred;
    logic [31:0]   r_q_inst [QUEUE_DEPTH];
    logic [31:0]   r_q_pc   [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] r_q_pred;
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_count;
    logic          w_flush, w_push, w_pop;
    logic [6:0]    w_opcode;
    logic [31:0]   w_imm_b;

    assign w_flush  = rdy_in && rob_to_if_flush;
    assign w_push   = rdy_in && ic_to_if_ready && r_state == WAIT;
    assign w_pop    = rdy_in && dec_to_if_ready && r_count != '0;
    assign w_opcode = ic_to_if_inst[6:0];
    assign w_imm_b  = {{20{ic_to_if_inst[31]}}, ic_to_if_inst[7], ic_to_if_inst[30:25],
                       ic_to_if_inst[11:8], 1'b0};
`ifdef IF_STATIC_JAL_EN
    logic [31:0] w_imm_j;
    assign w_imm_j  = {{12{ic_to_if_inst[31]}}, ic_to_if_inst[19:12], ic_to_if_inst[20],
                       ic_to_if_inst[30:21], 1'b0};
`endif

    always_comb begin
        w_next_pc   = r_pc + 32'd4;
        w_next_pred = 1'b0;
        if (w_opcode == 7'b1100011 && pr_to_if_prediction) begin
            w_next_pc   = r_pc + w_imm_b;
            w_next_pred = 1'b1;
        end
`ifdef IF_STATIC_JAL_EN
        if (w_opcode == 7'b1101111) begin
            w_next_pc   = r_pc + w_imm_j;
            w_next_pred = 1'b1;
        end
`endif
    end

    // An outstanding request cannot be cancelled, so a flush while waiting parks in DISCARD.
    always_comb begin
        w_next_state = r_state;
        if (rdy_in) begin
            if (r_state == IDLE)
                w_next_state = (!rob_to_if_flush && r_count < FULL) ? WAIT : IDLE;
            else if (ic_to_if_ready)
                w_next_state = IDLE;
            else if (r_state == WAIT && rob_to_if_flush)
                w_next_state = DISCARD;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_next_state;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pc     <= RESET_PC;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_q_pred <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_inst[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (w_flush) begin
            r_pc    <= rob_to_if_target;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_inst[r_tail] <= ic_to_if_inst;
                r_q_pc[r_tail]   <= r_pc;
                r_q_pred[r_tail] <= w_next_pred;
                r_tail           <= r_tail + AW'(1);
                r_pc             <= w_next_pc;
            end
            if (w_pop)
                r_head <= r_head + AW'(1);
            if (w_push != w_pop)
                r_count <= w_push ? r_count + (AW+1)'(1) : r_count - (AW+1)'(1);
        end
    end

    assign if_to_ic_valid  = r_state != IDLE;
    assign if_to_ic_PC     = r_pc;
    assign if_to_pr_PC     = r_pc;
    assign if_to_dec_valid = r_count != '0;
    assign if_to_dec_inst  = r_q_inst[r_head];
    assign if_to_dec_PC    = r_q_pc[r_head];
    assign if_to_dec_pred  = r_q_pred[r_head];
endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher: directed stimulus with a scoreboard queue checked at each decoder pop.
module tb_instr_fetcher;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        if_to_ic_valid;
    logic [31:0] if_to_ic_PC;
    logic        ic_to_if_ready = 1'b0;
    logic [31:0] ic_to_if_inst = '0;
    logic [31:0] if_to_pr_PC;
    logic        pr_to_if_prediction = 1'b0;
    logic        if_to_dec_valid;
    logic [31:0] if_to_dec_inst;
    logic [31:0] if_to_dec_PC;
    logic        if_to_dec_pred;
    logic        dec_to_if_ready = 1'b0;
    logic        rob_to_if_flush = 1'b0;
    logic [31:0] rob_to_if_target = '0;

    int checks = 0;
    int failures = 0;
    logic [64:0] exp_q [$];

`ifdef IF_STATIC_JAL_EN
    localparam logic [31:0] JAL_NXT = 32'h28;
    localparam logic        JAL_PRED = 1'b1;
`else
    localparam logic [31:0] JAL_NXT = 32'h24;
    localparam logic        JAL_PRED = 1'b0;
`endif
    localparam logic [31:0] ADDI = 32'h00000013;

    instr_fetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .if_to_ic_valid(if_to_ic_valid), .if_to_ic_PC(if_to_ic_PC),
        .ic_to_if_ready(ic_to_if_ready), .ic_to_if_inst(ic_to_if_inst),
        .if_to_pr_PC(if_to_pr_PC), .pr_to_if_prediction(pr_to_if_prediction),
        .if_to_dec_valid(if_to_dec_valid), .if_to_dec_inst(if_to_dec_inst),
        .if_to_dec_PC(if_to_dec_PC), .if_to_dec_pred(if_to_dec_pred),
        .dec_to_if_ready(dec_to_if_ready), .rob_to_if_flush(rob_to_if_flush),
        .rob_to_if_target(rob_to_if_target)
    );

    always #5 clk_in = ~clk_in;

    // Monitor: every accepted decoder pop must match the oldest expected entry.
    always @(negedge clk_in) begin
        if (rst_n_in && rdy_in && if_to_dec_valid && dec_to_if_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL dec_pop: unexpected entry inst=%h pc=%h pred=%b", if_to_dec_inst, if_to_dec_PC, if_to_dec_pred);
            end else if ({if_to_dec_inst, if_to_dec_PC, if_to_dec_pred} !== exp_q[0]) begin
                failures++;
                $display("FAIL dec_pop: got inst=%h pc=%h pred=%b want inst=%h pc=%h pred=%b",
                         if_to_dec_inst, if_to_dec_PC, if_to_dec_pred, exp_q[0][64:33], exp_q[0][32:1], exp_q[0][0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!if_to_ic_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_valid", 32'(if_to_ic_valid), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] inst, input logic pred, input logic [31:0] pc,
                         input logic [31:0] nxt, input logic epred, input int lat, input logic pop);
        logic old;
        wait_req();
        chk("req_pc", if_to_ic_PC, pc);
        chk("pr_pc", if_to_pr_PC, pc);
        repeat (lat) tick();
        old = dec_to_if_ready;
        ic_to_if_ready = 1'b1;
        ic_to_if_inst = inst;
        pr_to_if_prediction = pred;
        if (pop) dec_to_if_ready = 1'b1;
        exp_q.push_back({inst, pc, epred});
        tick();
        ic_to_if_ready = 1'b0;
        pr_to_if_prediction = 1'b0;
        dec_to_if_ready = old;
        chk("next_pc", if_to_ic_PC, nxt);
    endtask

    task automatic drain();
        int n = 0;
        dec_to_if_ready = 1'b1;
        while (if_to_dec_valid && n < 20) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(if_to_dec_valid), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_ic_valid", 32'(if_to_ic_valid), 32'd0);
        chk("rst_ic_pc", if_to_ic_PC, 32'h0);
        chk("rst_pr_pc", if_to_pr_PC, 32'h0);
        chk("rst_dec_valid", 32'(if_to_dec_valid), 32'd0);
        chk("rst_dec_inst", if_to_dec_inst, 32'h0);
        chk("rst_dec_pc", if_to_dec_PC, 32'h0);
        chk("rst_dec_pred", 32'(if_to_dec_pred), 32'd0);
        #1 rst_n_in = 1'b1;
        dec_to_if_ready = 1'b1;

        fetch(ADDI, 1'b0, 32'h00, 32'h04, 1'b0, 0, 1'b0);
        fetch(ADDI, 1'b1, 32'h04, 32'h08, 1'b0, 2, 1'b0);
        fetch(ADDI, 1'b0, 32'h08, 32'h0C, 1'b0, 0, 1'b0);
        fetch(ADDI, 1'b0, 32'h0C, 32'h10, 1'b0, 1, 1'b0);
        fetch(32'hFE000EE3, 1'b1, 32'h10, 32'h0C, 1'b1, 0, 1'b0);
        fetch(ADDI, 1'b0, 32'h0C, 32'h10, 1'b0, 0, 1'b0);
        fetch(32'hFE000EE3, 1'b0, 32'h10, 32'h14, 1'b0, 3, 1'b0);
        for (int i = 0; i < 3; i++)
            fetch(ADDI, 1'b0, 32'h14 + 32'(4 * i), 32'h18 + 32'(4 * i), 1'b0, 0, 1'b0);
        fetch(32'h0080006F, 1'b0, 32'h20, JAL_NXT, JAL_PRED, 0, 1'b0);

        drain();
        dec_to_if_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            fetch(ADDI, 1'b0, JAL_NXT + 32'(4 * i), JAL_NXT + 32'(4 * i + 4), 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_stall", 32'(if_to_ic_valid), 32'd0);
        end
        chk("full_dec_valid", 32'(if_to_dec_valid), 32'd1);
        dec_to_if_ready = 1'b1;
        tick();
        dec_to_if_ready = 1'b0;
        fetch(ADDI, 1'b0, JAL_NXT + 32'd16, JAL_NXT + 32'd20, 1'b0, 0, 1'b1);
        chk("pushpop_valid", 32'(if_to_dec_valid), 32'd1);
        drain();

        wait_req();
        rob_to_if_flush = 1'b1;
        rob_to_if_target = 32'h100;
        exp_q.delete();
        tick();
        rob_to_if_flush = 1'b0;
        chk("flush_dec_valid", 32'(if_to_dec_valid), 32'd0);
        chk("flush_ic_pc", if_to_ic_PC, 32'h100);
        chk("flush_pr_pc", if_to_pr_PC, 32'h100);
        chk("discard_valid", 32'(if_to_ic_valid), 32'd1);
        repeat (2) tick();
        ic_to_if_ready = 1'b1;
        ic_to_if_inst = 32'h00000093;
        tick();
        ic_to_if_ready = 1'b0;
        chk("discard_drop", 32'(if_to_dec_valid), 32'd0);
        chk("discard_pc", if_to_ic_PC, 32'h100);
        fetch(32'h00100113, 1'b0, 32'h100, 32'h104, 1'b0, 0, 1'b0);

        wait_req();
        rdy_in = 1'b0;
        ic_to_if_ready = 1'b1;
        rob_to_if_flush = 1'b1;
        rob_to_if_target = 32'h200;
        tick();
        ic_to_if_ready = 1'b0;
        rob_to_if_flush = 1'b0;
        chk("frz_ic_valid", 32'(if_to_ic_valid), 32'd1);
        chk("frz_ic_pc", if_to_ic_PC, 32'h104);
        chk("frz_dec_valid", 32'(if_to_dec_valid), 32'd0);
        rdy_in = 1'b1;

        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_ic_valid", 32'(if_to_ic_valid), 32'd0);
        chk("arst_ic_pc", if_to_ic_PC, 32'h0);
        chk("arst_pr_pc", if_to_pr_PC, 32'h0);
        exp_q.delete();
        @(posedge clk_in);
        #2 rst_n_in = 1'b1;
        ic_to_if_ready = 1'b1;
        ic_to_if_inst = ADDI;
        tick();
        ic_to_if_ready = 1'b0;
        chk("late_rdy_dec", 32'(if_to_dec_valid), 32'd0);
        chk("late_rdy_pc", if_to_ic_PC, 32'h0);
        chk("late_rdy_req", 32'(if_to_ic_valid), 32'd1);
        fetch(ADDI, 1'b0, 32'h0, 32'h4, 1'b0, 1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
